ldpc_sched_ctrl: RTL

LDPC_SCHED_CTRL -- requirements
Module: ldpc_sched_ctrl

---
 rtl/ldpc_sched_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ldpc_sched_ctrl.sv
// Iteration scheduler for a layered QC-LDPC decoder: frame load, alternating check/variable
// passes with pipeline-drain gaps, and syndrome-driven early termination.
module ldpc_sched_ctrl #(
   parameter int unsigned CIRC         = 31,
   parameter int unsigned LOG2CIRC     = 6,
   parameter int unsigned MAX_ITER     = 30,
   parameter int unsigned LOG2MAX_ITER = 5,
   parameter int unsigned PIPE_GAP     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    syn_valid,
   input  logic                    syn_ok,
   output logic [3:0]              fsm,
   output logic                    busy,
   output logic                    load_en,
   output logic                    proc_en,
   output logic                    phase,
   output logic [LOG2CIRC-1:0]     circ_addr,
   output logic                    syn_req,
   output logic                    success,
   output logic [LOG2MAX_ITER-1:0] iterations
);

   localparam int unsigned GAP_W = $clog2(PIPE_GAP + 1);
   localparam int unsigned CNT_W = (LOG2CIRC > GAP_W) ? LOG2CIRC : GAP_W;
   localparam logic [CNT_W-1:0]        CIRC_LAST = CNT_W'(CIRC - 1);
   localparam logic [CNT_W-1:0]        GAP_LAST  = CNT_W'(PIPE_GAP - 1);
   localparam logic [LOG2MAX_ITER-1:0] ITER_MAX  = LOG2MAX_ITER'(MAX_ITER);

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StLoad    = 4'd1,
      StInitSyn = 4'd2,
      StDone    = 4'd3,
      StPassA   = 4'd4,
      StGapA    = 4'd5,
      StPassB   = 4'd6,
      StGapB    = 4'd7,
      StSynWait = 4'd8
   } state_e;

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     success_d, syn_req_d;
   logic [LOG2MAX_ITER-1:0]  iter_d;
   logic                     busy_d, load_en_d, proc_en_d, phase_d;
   logic [LOG2CIRC-1:0]      addr_d;

   assign fsm = state_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      success_d = success;
      iter_d    = iterations;
      syn_req_d = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StLoad;
               cnt_d     = '0;
               success_d = 1'b0;
               iter_d    = '0;
            end
         end
         StLoad: begin
            if (cnt_q == CIRC_LAST) begin
               state_d   = StInitSyn;
               cnt_d     = '0;
               syn_req_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StInitSyn: begin
            if (syn_valid) begin
               cnt_d = '0;
               if (syn_ok) begin
                  state_d   = StDone;
                  success_d = 1'b1;
                  iter_d    = '0;
               end else begin
                  state_d = StPassA;
               end
            end
         end
         StPassA, StPassB: begin
            if (cnt_q == CIRC_LAST) begin
               state_d = (state_q == StPassA) ? StGapA : StGapB;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGapA: begin
            if (cnt_q == GAP_LAST) begin
               state_d = StPassB;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGapB: begin
            if (cnt_q == GAP_LAST) begin
               state_d   = StSynWait;
               cnt_d     = '0;
               iter_d    = iterations + 1'b1;
               syn_req_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StSynWait: begin
            if (syn_valid) begin
               cnt_d = '0;
               if (syn_ok) begin
                  state_d   = StDone;
                  success_d = 1'b1;
               end else if (iterations == ITER_MAX) begin
                  state_d   = StDone;
                  success_d = 1'b0;
               end else begin
                  state_d = StPassA;
               end
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      // Output strobes are decoded from the next state so they register in step with fsm.
      busy_d    = (state_d != StIdle) && (state_d != StDone);
      load_en_d = (state_d == StLoad);
      proc_en_d = (state_d == StPassA) || (state_d == StPassB);
      phase_d   = (state_d == StPassB) || (state_d == StGapB);
      addr_d    = (load_en_d || proc_en_d) ? LOG2CIRC'(cnt_d) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         busy       <= 1'b0;
         load_en    <= 1'b0;
         proc_en    <= 1'b0;
         phase      <= 1'b0;
         circ_addr  <= '0;
         syn_req    <= 1'b0;
         success    <= 1'b0;
         iterations <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy       <= busy_d;
         load_en    <= load_en_d;
         proc_en    <= proc_en_d;
         phase      <= phase_d;
         circ_addr  <= addr_d;
         syn_req    <= syn_req_d;
         success    <= success_d;
         iterations <= iter_d;
      end
   end

endmodule
